// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg
//   Shared definitions for the SPI register bridge: FSM state encoding,
//   command-byte layout and fixed byte values.
//   Optional feature macro (used by spi_reg_bridge): SPI_REG_BRIDGE_STATUS_EN
// ---------------------------------------------------------------------------
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_e;

    localparam int          ADDR_W      = 7;
    localparam int          CMD_RW_BIT  = 7;         // 1 = write frame
    localparam logic [6:0]  STATUS_ADDR = 7'h7F;
    localparam logic [7:0]  TX_DUMMY    = 8'h00;     // MISO filler during the command byte

endpackage

// File: rtl/spi_cs_sync.sv
// ---------------------------------------------------------------------------
// spi_cs_sync
//   Two-flop synchronizer for the raw SPI chip select plus edge pulses on
//   the synchronized level. All flops reset to 1 (CS deasserted), so a CS
//   that is already low when reset releases shows up as a fresh fall.
// Ports
//   i_Clk    in  system clock
//   i_Rst    in  synchronous reset, active-high
//   i_CS_n   in  raw asynchronous chip select (active low)
//   o_Fall   out 1-cycle pulse: synchronized CS went 1->0 (frame start)
//   o_Rise   out 1-cycle pulse: synchronized CS went 0->1 (frame end)
// ---------------------------------------------------------------------------
module spi_cs_sync (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_CS_n,
    output logic o_Fall,
    output logic o_Rise
);

    logic cs_meta;
    logic cs_s;
    logic cs_d;     // previous synchronized level, for edge detection

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
            cs_d    <= 1'b1;
        end else begin
            cs_meta <= i_CS_n;
            cs_s    <= cs_meta;
            cs_d    <= cs_s;
        end
    end

    assign o_Fall = cs_d & ~cs_s;
    assign o_Rise = ~cs_d & cs_s;

endmodule

// File: rtl/spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// spi_reg_bridge
//   Byte-protocol engine behind an SPI slave. One CS_n-low period is one
//   frame; byte0 = {RW, ADDR[6:0]} (RW=1 write), following bytes are data
//   with the address pointer auto-incrementing (7-bit, wraps 7F->00).
//   Read data goes back to the slave one cycle after each received byte.
// Optional feature: define SPI_REG_BRIDGE_STATUS_EN to map address 7'h7F as a
//   read-only status byte taken from i_Status (writes to it are dropped).
// Parameters
//   NUM_REGS  number of 8-bit registers at addresses 0..NUM_REGS-1 (1..127)
//   REG_RST   reset value of every register
// Ports
//   i_Clk, i_Rst           clock, synchronous active-high reset
//   i_SPI_CS_n             raw chip select (synchronized internally)
//   i_RX_DV, i_RX_Byte     received byte strobe and value
//   o_TX_DV, o_TX_Byte     load strobe and next MISO byte for the slave
//   o_Regs                 register bank, reg n at [8n+7:8n]
//   o_Wr_Stb, o_Wr_Addr    pulse and address per accepted register write
//   i_Status               status byte (feature build only)
// ---------------------------------------------------------------------------
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [7:0]  REG_RST  = 8'h00
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_SPI_CS_n,
    input  logic                    i_RX_DV,
    input  logic [7:0]              i_RX_Byte,
    output logic                    o_TX_DV,
    output logic [7:0]              o_TX_Byte,
    output logic [NUM_REGS*8-1:0]   o_Regs,
    output logic                    o_Wr_Stb,
    output logic [ADDR_W-1:0]       o_Wr_Addr,
    input  logic [7:0]              i_Status
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic cs_fall;
    logic cs_rise;

    spi_cs_sync u_cs_sync (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_CS_n (i_SPI_CS_n),
        .o_Fall (cs_fall),
        .o_Rise (cs_rise)
    );

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                tx_dv_d;
    logic [7:0]          tx_byte_d;
    logic                wr_stb_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic                reg_we;
    logic [7:0]          regs_q [NUM_REGS];

    logic [ADDR_W-1:0]   rd_addr;
    logic [7:0]          rd_data;
    logic                wr_ok;

    // Read address: the command byte's address when entering a read, the
    // incremented pointer while streaming.
    always_comb begin
        rd_addr = (state_q == ST_CMD) ? i_RX_Byte[ADDR_W-1:0] : ptr_q + 7'd1;
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
        end
`ifdef SPI_REG_BRIDGE_STATUS_EN
        if (rd_addr == STATUS_ADDR) rd_data = i_Status;
`endif
    end

`ifdef SPI_REG_BRIDGE_STATUS_EN
    assign wr_ok = ({1'b0, ptr_q} < NUM_REGS_W) && (ptr_q != STATUS_ADDR);
`else
    assign wr_ok = ({1'b0, ptr_q} < NUM_REGS_W);
    wire unused_status = ^i_Status;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = o_TX_Byte;
        wr_stb_d  = 1'b0;
        wr_addr_d = o_Wr_Addr;
        reg_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = TX_DUMMY;
                end
            end
            ST_CMD: begin
                if (i_RX_DV) begin
                    ptr_d = i_RX_Byte[ADDR_W-1:0];
                    if (i_RX_Byte[CMD_RW_BIT]) begin
                        state_d = ST_WR;
                    end else begin
                        state_d   = ST_RD;
                        tx_dv_d   = 1'b1;
                        tx_byte_d = rd_data;
                    end
                end
            end
            ST_WR: begin
                if (i_RX_DV) begin
                    if (wr_ok) begin
                        reg_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                    end
                    ptr_d = ptr_q + 7'd1;
                end
            end
            ST_RD: begin
                // Incoming byte is a dummy; it only paces the next read.
                if (i_RX_DV) begin
                    ptr_d     = ptr_q + 7'd1;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = rd_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // End of frame wins over the state decision but not over the byte
        // handled in the same cycle.
        if (cs_rise) state_d = ST_IDLE;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
            o_Wr_Stb  <= 1'b0;
            o_Wr_Addr <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            o_TX_DV   <= tx_dv_d;
            o_TX_Byte <= tx_byte_d;
            o_Wr_Stb  <= wr_stb_d;
            o_Wr_Addr <= wr_addr_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST;
        end else if (reg_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ptr_q == ADDR_W'(i)) regs_q[i] <= i_RX_Byte;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign o_Regs[8*g +: 8] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;

    localparam int         NUM_REGS   = 16;
    localparam logic [7:0] REG_RST    = 8'h00;
    localparam logic [7:0] STATUS_VAL = 8'h3C;

    logic                  i_Clk = 1'b0;
    logic                  i_Rst;
    logic                  i_SPI_CS_n;
    logic                  i_RX_DV;
    logic [7:0]            i_RX_Byte;
    logic                  o_TX_DV;
    logic [7:0]            o_TX_Byte;
    logic [NUM_REGS*8-1:0] o_Regs;
    logic                  o_Wr_Stb;
    logic [6:0]            o_Wr_Addr;
    logic [7:0]            i_Status;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] frame_q [$];

    spi_reg_bridge #(.NUM_REGS(NUM_REGS), .REG_RST(REG_RST)) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_SPI_CS_n (i_SPI_CS_n),
        .i_RX_DV    (i_RX_DV),
        .i_RX_Byte  (i_RX_Byte),
        .o_TX_DV    (o_TX_DV),
        .o_TX_Byte  (o_TX_Byte),
        .o_Regs     (o_Regs),
        .o_Wr_Stb   (o_Wr_Stb),
        .o_Wr_Addr  (o_Wr_Addr),
        .i_Status   (i_Status)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference read: register, status (feature build) or zero.
    function automatic logic [7:0] m_rd(input logic [6:0] a);
        if (int'(a) < NUM_REGS) return m_regs[int'(a)];
`ifdef SPI_REG_BRIDGE_STATUS_EN
        if (a == 7'h7F) return STATUS_VAL;
`endif
        return 8'h00;
    endfunction

    function automatic bit m_wr_ok(input logic [6:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_Clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(posedge i_Clk); #1;
        i_RX_DV   = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) chk(tag, o_Regs[8*i +: 8], m_regs[i]);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = REG_RST;
    endtask

    // Drive one whole frame from frame_q and check every response byte,
    // write strobe and the final register bank.
    task automatic run_frame();
        logic [6:0] a0;
        logic [6:0] a;
        bit         wr;
        bit         seen;
        a0   = frame_q[0][6:0];
        wr   = frame_q[0][7];
        seen = 0;
        i_SPI_CS_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge i_Clk); #1;
            if (o_TX_DV) begin
                seen = 1;
                break;
            end
        end
        chk("start_dv", 32'(seen), 1);
        chk("start_byte", o_TX_Byte, 8'h00);
        @(posedge i_Clk); #1;
        chk("start_dv_pulse", o_TX_DV, 0);
        for (int k = 0; k < frame_q.size(); k++) begin
            send_byte(frame_q[k]);
            if (wr && k == 0) begin
                chk("wcmd_tx_dv", o_TX_DV, 0);
                chk("wcmd_stb", o_Wr_Stb, 0);
            end else if (wr) begin
                a = a0 + 7'(k - 1);
                chk("tx_dv_in_wr", o_TX_DV, 0);
                chk("wr_stb", o_Wr_Stb, 32'(m_wr_ok(a)));
                if (m_wr_ok(a)) begin
                    chk("wr_addr", o_Wr_Addr, a);
                    m_regs[int'(a)] = frame_q[k];
                end
            end else begin
                a = a0 + 7'(k);
                chk("rd_dv", o_TX_DV, 1);
                chk("rd_byte", o_TX_Byte, m_rd(a));
                chk("stb_in_rd", o_Wr_Stb, 0);
            end
            @(posedge i_Clk); #1;
            chk("tx_dv_pulse", o_TX_DV, 0);
            chk("stb_pulse", o_Wr_Stb, 0);
            idle(2);
        end
        i_SPI_CS_n = 1'b1;
        idle(5);
        check_regs("regs_after_frame");
    endtask

    initial begin
        logic [6:0] a;
        int         len;
        i_Rst      = 1'b1;
        i_SPI_CS_n = 1'b1;
        i_RX_DV    = 1'b0;
        i_RX_Byte  = 8'h00;
        i_Status   = STATUS_VAL;
        m_reset();
        idle(3);
        i_Rst = 1'b0;
        #1;
        chk("rst_tx_dv", o_TX_DV, 0);
        chk("rst_tx_byte", o_TX_Byte, 0);
        chk("rst_wr_stb", o_Wr_Stb, 0);
        chk("rst_wr_addr", o_Wr_Addr, 0);
        check_regs("rst_regs");

        // Bytes while idle are ignored.
        send_byte(8'h81);
        chk("idle_rx_tx_dv", o_TX_DV, 0);
        chk("idle_rx_stb", o_Wr_Stb, 0);
        idle(2);

        frame_q = '{8'h82, 8'h11, 8'h22};            run_frame();
        frame_q = '{8'h85, 8'hA5, 8'h5A};            run_frame();
        frame_q = '{8'h05, 8'h00, 8'hFF, 8'h00};     run_frame();
        frame_q = '{8'h8F, 8'h77, 8'h88};            run_frame();
        frame_q = '{8'h7F, 8'h00};                   run_frame();
        frame_q = '{8'h83};                          run_frame();   // aborted write
        frame_q = '{8'h83, 8'h44};                   run_frame();
        frame_q = '{8'hFF, 8'h99};                   run_frame();
        frame_q = '{8'h7E, 8'h00, 8'h00, 8'h00};     run_frame();

        // Reset in the middle of a write frame.
        frame_q = '{8'h84, 8'h12};
        i_SPI_CS_n = 1'b0;
        idle(5);
        send_byte(8'h84); idle(2);
        send_byte(8'h12);
        chk("mid_stb", o_Wr_Stb, 1);
        idle(2);
        i_Rst = 1'b1;
        @(posedge i_Clk); #1;
        i_Rst = 1'b0;
        m_reset();
        chk("mid_rst_tx_byte", o_TX_Byte, 0);
        chk("mid_rst_tx_dv", o_TX_DV, 0);
        check_regs("mid_rst_regs");
        send_byte(8'h66);
        chk("post_rst_stb", o_Wr_Stb, 0);
        chk("post_rst_tx_dv", o_TX_DV, 0);
        idle(3);
        i_SPI_CS_n = 1'b1;
        idle(6);
        check_regs("post_rst_regs");

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 3))
                0:       a = 7'($urandom_range(0, 127));
                1:       a = 7'($urandom_range(0, NUM_REGS - 1));
                2:       a = 7'($urandom_range(NUM_REGS - 3, NUM_REGS + 1));
                default: a = 7'($urandom_range(124, 127));
            endcase
            len = $urandom_range(1, 6);
            frame_q = {};
            frame_q.push_back({1'($urandom_range(0, 1)), a});
            for (int k = 1; k < len; k++) frame_q.push_back(8'($urandom));
            run_frame();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
